mem_stage_lsu: RTL and testbench

MEM-stage load/store unit and the producer side of the writeback select path. It turns EX/MEM load/store controls into a req/ack transaction on the data memory. It forms byte enables and replicated store data, applying the RS2 forward from the writeback value. It returns a formatted, sign- or zero-extended read_data word to the MEM/WB writeback select, and stalls the pipeline while the access is outstanding.

---
 rtl/mem_stage_lsu.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//
// MEM-stage load/store unit. Converts the EX/MEM load/store controls into a
// single req/ack transaction on the data memory, builds byte enables and
// lane-replicated store data (with the RS2 forward from writeback applied),
// and formats the returned word into a sign/zero-extended read_data value
// for the MEM/WB writeback select. The pipeline is stalled while an access
// is pending.
//
// Ports:
//   clk, rst               : clock (rising edge), synchronous active-high reset
//   ex_mem_memread/write   : load / store request (write wins if both set)
//   ex_mem_funct3          : 000 B, 001 H, 010 W, 100 BU, 101 HU (others = W)
//   ex_mem_result          : byte address from the ALU
//   ex_mem_output_data_2   : RS2 store data from EX/MEM
//   ex_mem_FWD_RS2         : 2'b01 selects wb_write_data as store data
//   wb_write_data          : current writeback-stage data
//   dmem_req/we/addr/wdata/be : registered memory request, held until ack
//   dmem_rdata, dmem_ack   : memory response (one-cycle ack)
//   read_data              : formatted load data for writeback
//   mem_stall              : freeze IF..EX/MEM registers
//   misaligned             : one-cycle pulse on an alignment fault
//   timeout_err            : sticky flag, access aborted after MAX_WAIT cycles

module mem_stage_lsu #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_memread,
    input  logic        ex_mem_memwrite,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [31:0] ex_mem_result,
    input  logic [31:0] ex_mem_output_data_2,
    input  logic [1:0]  ex_mem_FWD_RS2,
    input  logic [31:0] wb_write_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] read_data,
    output logic        mem_stall,
    output logic        misaligned,
    output logic        timeout_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           dmem_req_q, dmem_req_d;
    logic           dmem_we_q, dmem_we_d;
    logic [31:0]    dmem_addr_q, dmem_addr_d;
    logic [31:0]    dmem_wdata_q, dmem_wdata_d;
    logic [3:0]     dmem_be_q, dmem_be_d;
    logic [1:0]     addr_lo_q, addr_lo_d;
    logic [2:0]     funct3_q, funct3_d;
    logic [31:0]    read_data_q, read_data_d;
    logic           misaligned_q, misaligned_d;
    logic           timeout_q, timeout_d;

    // ------------------------------------------------------------------
    // Request decode (EX/MEM side)
    // ------------------------------------------------------------------
    logic        is_req;
    logic        size_b;
    logic        size_h;
    logic        aligned;
    logic [31:0] store_src;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    assign is_req    = ex_mem_memread | ex_mem_memwrite;
    // funct3[2] only carries signedness; any encoding that is neither a
    // byte nor a half access is handled as a full word.
    assign size_b    = (ex_mem_funct3 == 3'b000) || (ex_mem_funct3 == 3'b100);
    assign size_h    = (ex_mem_funct3 == 3'b001) || (ex_mem_funct3 == 3'b101);
    assign aligned   = size_b ? 1'b1 :
                       size_h ? ~ex_mem_result[0] :
                                (ex_mem_result[1:0] == 2'b00);
    assign store_src = (ex_mem_FWD_RS2 == 2'b01) ? wb_write_data : ex_mem_output_data_2;

    always_comb begin
        if (size_b) begin
            be_new = 4'b0001 << ex_mem_result[1:0];
        end else if (size_h) begin
            be_new = ex_mem_result[1] ? 4'b1100 : 4'b0011;
        end else begin
            be_new = 4'b1111;
        end
    end

    // Replicate the low byte/half across every lane so the memory only has
    // to honour the byte enables.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign wdata_new[8*gi +: 8] = size_b ? store_src[7:0] :
                                      size_h ? store_src[8*(gi%2) +: 8] :
                                               store_src[8*gi +: 8];
    end

    // ------------------------------------------------------------------
    // Load formatting, driven from the latched address/size
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    always_comb begin
        ld_byte = dmem_rdata[8*addr_lo_q +: 8];
        ld_half = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        addr_lo_d    = addr_lo_q;
        funct3_d     = funct3_q;
        read_data_d  = read_data_q;
        misaligned_d = 1'b0;
        timeout_d    = timeout_q;

        case (state_q)
            IDLE: begin
                if (is_req) begin
                    if (aligned) begin
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = ex_mem_memwrite;
                        dmem_addr_d  = {ex_mem_result[31:2], 2'b00};
                        dmem_wdata_d = wdata_new;
                        dmem_be_d    = be_new;
                        addr_lo_d    = ex_mem_result[1:0];
                        funct3_d     = ex_mem_funct3;
                        wait_cnt_d   = '0;
                        state_d      = ACCESS;
                    end else begin
                        // Fault: no memory traffic; flag is visible in DONE.
                        misaligned_d = 1'b1;
                        state_d      = DONE;
                    end
                end
            end

            ACCESS: begin
                if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    wait_cnt_d = '0;
                    if (!dmem_we_q) begin
                        read_data_d = ld_fmt;
                    end
                    state_d = DONE;
                end else if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
                    // This cycle is the MAX_WAIT-th without an ack: abort.
                    dmem_req_d = 1'b0;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b1;
                    if (!dmem_we_q) begin
                        read_data_d = 32'h0;
                    end
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end

            DONE: begin
                // The pipeline advances at the end of this cycle, so the
                // entry just serviced is never seen again in IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d    = IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'h0;
            dmem_wdata_q <= 32'h0;
            dmem_be_q    <= 4'h0;
            addr_lo_q    <= 2'b00;
            funct3_q     <= 3'b000;
            read_data_q  <= 32'h0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            addr_lo_q    <= addr_lo_d;
            funct3_q     <= funct3_d;
            read_data_q  <= read_data_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
        end
    end

    assign mem_stall   = ((state_q == IDLE) && is_req && aligned) || (state_q == ACCESS);
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign dmem_be     = dmem_be_q;
    assign read_data   = read_data_q;
    assign misaligned  = misaligned_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
//
// Bench for mem_stage_lsu: a vector table with hand-derived expectations,
// randomized transactions checked against a byte-level reference model,
// and hand-written timeout / reset-in-flight sequences.

module tb_mem_stage_lsu;

    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_memread;
    logic        ex_mem_memwrite;
    logic [2:0]  ex_mem_funct3;
    logic [31:0] ex_mem_result;
    logic [31:0] ex_mem_output_data_2;
    logic [1:0]  ex_mem_FWD_RS2;
    logic [31:0] wb_write_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] read_data;
    logic        mem_stall;
    logic        misaligned;
    logic        timeout_err;

    mem_stage_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex_mem_memread       (ex_mem_memread),
        .ex_mem_memwrite      (ex_mem_memwrite),
        .ex_mem_funct3        (ex_mem_funct3),
        .ex_mem_result        (ex_mem_result),
        .ex_mem_output_data_2 (ex_mem_output_data_2),
        .ex_mem_FWD_RS2       (ex_mem_FWD_RS2),
        .wb_write_data        (wb_write_data),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_be              (dmem_be),
        .dmem_rdata           (dmem_rdata),
        .dmem_ack             (dmem_ack),
        .read_data            (read_data),
        .mem_stall            (mem_stall),
        .misaligned           (misaligned),
        .timeout_err          (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] d2;
        logic [1:0]  fwd;
        logic [31:0] wbd;
        int          ack_at;   // ack on the n-th request cycle, 0 = never
        logic [31:0] rdata;
        logic [31:0] e_rd;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_mis;
        logic        e_to;
    } vec_t;

    typedef struct {
        int          stall;
        int          req;
        int          mis;
        logic [31:0] rd_done;
        logic [31:0] rd_end;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic        to_end;
    } obs_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rd_model = 32'h0;
    logic        to_model = 1'b0;
    vec_t        tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] d2,
                                input logic [1:0] fwd, input logic [31:0] wbd,
                                input int ack_at, input logic [31:0] rdata,
                                input logic [31:0] e_rd, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic e_mis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.d2 = d2;
        v.fwd = fwd; v.wbd = wbd; v.ack_at = ack_at; v.rdata = rdata;
        v.e_rd = e_rd; v.e_be = e_be; v.e_wdata = e_wdata; v.e_mis = e_mis;
        v.e_to = 1'b0;
        return v;
    endfunction

    // Reference model: access size in bytes, offset in the word, lanes and
    // extension computed arithmetically.
    function automatic vec_t model(input vec_t v, input logic [31:0] prev_rd, input logic prev_to);
        vec_t        r;
        int          sz;
        int          off;
        logic [31:0] d;
        logic [31:0] ld;
        logic [31:0] mask;
        logic        req;
        logic        ok;
        r   = v;
        sz  = (v.f3 == 3'd0 || v.f3 == 3'd4) ? 1 : (v.f3 == 3'd1 || v.f3 == 3'd5) ? 2 : 4;
        off = int'(v.addr[1:0]);
        req = v.rd | v.wr;
        ok  = (off % sz) == 0;
        r.e_mis = req && !ok;
        d = (v.fwd == 2'b01) ? v.wbd : v.d2;
        r.e_be = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++) r.e_wdata[8*i +: 8] = d[8*(i % sz) +: 8];
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*sz)) - 32'h1);
        ld = (v.rdata >> (8*off)) & mask;
        if ((v.f3 == 3'd0 || v.f3 == 3'd1) && ld[8*sz-1]) ld = ld | ~mask;
        if (req && ok && !v.wr) r.e_rd = (v.ack_at == 0) ? 32'h0 : ld;
        else                    r.e_rd = prev_rd;
        r.e_to = prev_to || (req && ok && v.ack_at == 0);
        return r;
    endfunction

    function automatic int exp_req(input vec_t v);
        if (!(v.rd | v.wr) || v.e_mis) return 0;
        return (v.ack_at == 0) ? MAX_WAIT : v.ack_at;
    endfunction

    function automatic int done_idx(input vec_t v);
        if (!(v.rd | v.wr)) return 0;
        if (v.e_mis) return 1;
        return exp_req(v) + 1;
    endfunction

    // Entered and left on a falling edge. Cycle 0 is the IDLE request cycle;
    // the request is held through the expected DONE cycle, then dropped.
    task automatic run_txn(input vec_t v, output obs_t o);
        int dk;
        dk = done_idx(v);
        o.stall = 0; o.req = 0; o.mis = 0;
        o.rd_done = 32'h0; o.rd_end = 32'h0; o.addr = 32'h0; o.wdata = 32'h0;
        o.be = 4'h0; o.we = 1'b0; o.to_end = 1'b0;
        ex_mem_memread       = v.rd;
        ex_mem_memwrite      = v.wr;
        ex_mem_funct3        = v.f3;
        ex_mem_result        = v.addr;
        ex_mem_output_data_2 = v.d2;
        ex_mem_FWD_RS2       = v.fwd;
        wb_write_data        = v.wbd;
        dmem_ack             = 1'b0;
        for (int k = 0; k < dk + 3; k++) begin
            #1;
            if (mem_stall) o.stall++;
            if (misaligned) o.mis++;
            if (dmem_req) begin
                o.req++;
                if (o.req == 1) begin
                    o.addr = dmem_addr; o.wdata = dmem_wdata; o.be = dmem_be; o.we = dmem_we;
                end
            end
            if (k == dk) o.rd_done = read_data;
            o.rd_end = read_data;
            o.to_end = timeout_err;
            if (dmem_req && o.req == v.ack_at) begin
                dmem_ack = 1'b1; dmem_rdata = v.rdata;
            end else begin
                dmem_ack = 1'b0; dmem_rdata = $urandom;
            end
            if (k + 1 > dk) begin
                ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0;
            end
            @(negedge clk);
        end
        dmem_ack = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        obs_t o;
        int   er;
        run_txn(v, o);
        er = exp_req(v);
        check($sformatf("%s.stall_cycles", tag), o.stall, (er > 0) ? er + 1 : 0);
        check($sformatf("%s.req_cycles", tag), o.req, er);
        check($sformatf("%s.misaligned_cycles", tag), o.mis, v.e_mis ? 1 : 0);
        check($sformatf("%s.read_data_done", tag), o.rd_done, v.e_rd);
        check($sformatf("%s.read_data_hold", tag), o.rd_end, v.e_rd);
        check($sformatf("%s.timeout_err", tag), o.to_end, v.e_to);
        if (er > 0) begin
            check($sformatf("%s.dmem_be", tag), o.be, v.e_be);
            check($sformatf("%s.dmem_we", tag), o.we, v.wr);
            check($sformatf("%s.dmem_addr", tag), o.addr, {v.addr[31:2], 2'b00});
            if (v.wr) check($sformatf("%s.dmem_wdata", tag), o.wdata, v.e_wdata);
        end
        $display("txn %s: rd=%0d wr=%0d f3=%0d addr=%08h stall=%0d req=%0d mis=%0d read_data=%08h",
                 tag, v.rd, v.wr, v.f3, v.addr, o.stall, o.req, o.mis, o.rd_end);
        rd_model = v.e_rd;
        to_model = v.e_to;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1'b1;
        ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0; ex_mem_funct3 = 3'b0;
        ex_mem_result = 32'h0; ex_mem_output_data_2 = 32'h0; ex_mem_FWD_RS2 = 2'b0;
        wb_write_data = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset.dmem_req", dmem_req, 0);
        check("reset.dmem_we", dmem_we, 0);
        check("reset.dmem_addr", dmem_addr, 0);
        check("reset.dmem_wdata", dmem_wdata, 0);
        check("reset.dmem_be", dmem_be, 0);
        check("reset.read_data", read_data, 0);
        check("reset.mem_stall", mem_stall, 0);
        check("reset.misaligned", misaligned, 0);
        check("reset.timeout_err", timeout_err, 0);
        rst = 1'b0;
        @(negedge clk);

        //            rd wr f3      addr          d2            fwd    wbd           ack rdata          e_rd          e_be     e_wdata       mis
        tbl[0]  = mk(1, 0, 3'd2, 32'h0000_0100, 32'h0,        2'b00, 32'h0,        3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'h0,        0);
        tbl[1]  = mk(1, 0, 3'd0, 32'h0000_0103, 32'h0,        2'b00, 32'h0,        1, 32'h80FF_FF7F, 32'hFFFF_FF80, 4'b1000, 32'h0,        0);
        tbl[2]  = mk(1, 0, 3'd4, 32'h0000_0103, 32'h0,        2'b00, 32'h0,        1, 32'h80FF_FF7F, 32'h0000_0080, 4'b1000, 32'h0,        0);
        tbl[3]  = mk(1, 0, 3'd5, 32'h0000_0102, 32'h0,        2'b00, 32'h0,        1, 32'h80FF_FF7F, 32'h0000_80FF, 4'b1100, 32'h0,        0);
        tbl[4]  = mk(1, 0, 3'd1, 32'h0000_0100, 32'h0,        2'b00, 32'h0,        1, 32'h80FF_FF7F, 32'hFFFF_FF7F, 4'b0011, 32'h0,        0);
        tbl[5]  = mk(0, 1, 3'd0, 32'h0000_0201, 32'h11,       2'b01, 32'hAB,       2, 32'h0,         32'hFFFF_FF7F, 4'b0010, 32'hABAB_ABAB, 0);
        tbl[6]  = mk(0, 1, 3'd1, 32'h0000_0301, 32'h1234,     2'b00, 32'h0,        1, 32'h0,         32'hFFFF_FF7F, 4'b0000, 32'h0,        1);
        tbl[7]  = mk(0, 1, 3'd2, 32'h0000_030C, 32'h1234_5678, 2'b10, 32'hFFFF_FFFF, 1, 32'h0,       32'hFFFF_FF7F, 4'b1111, 32'h1234_5678, 0);
        tbl[8]  = mk(1, 0, 3'd2, 32'h0000_0102, 32'h0,        2'b00, 32'h0,        1, 32'h5555_5555, 32'hFFFF_FF7F, 4'b0000, 32'h0,        1);
        tbl[9]  = mk(1, 0, 3'd3, 32'h0000_0104, 32'h0,        2'b00, 32'h0,        1, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 32'h0,        0);
        tbl[10] = mk(0, 1, 3'd1, 32'h0000_0302, 32'h0000_BEEF, 2'b00, 32'h1111_1111, 4, 32'h0,       32'hCAFE_F00D, 4'b1100, 32'hBEEF_BEEF, 0);
        tbl[11] = mk(1, 1, 3'd2, 32'h0000_0400, 32'h55AA_55AA, 2'b11, 32'h0,        1, 32'h9999_9999, 32'hCAFE_F00D, 4'b1111, 32'h55AA_55AA, 0);
        tbl[12] = mk(1, 0, 3'd0, 32'h0000_0001, 32'h0,        2'b00, 32'h0,        2, 32'h0000_7F00, 32'h0000_007F, 4'b0010, 32'h0,        0);
        tbl[13] = mk(0, 0, 3'd2, 32'h0000_0700, 32'h0,        2'b00, 32'h0,        1, 32'h0,         32'h0000_007F, 4'b0000, 32'h0,        0);
        tbl[14] = mk(1, 0, 3'd5, 32'h0000_0000, 32'h0,        2'b00, 32'h0,        1, 32'h1234_8001, 32'h0000_8001, 4'b0011, 32'h0,        0);
        tbl[15] = mk(0, 1, 3'd0, 32'h0000_0003, 32'hC3,       2'b00, 32'h0,        1, 32'h0,         32'h0000_8001, 4'b1000, 32'hC3C3_C3C3, 0);
        tbl[16] = mk(1, 0, 3'd1, 32'h0000_0003, 32'h0,        2'b00, 32'h0,        1, 32'hFFFF_FFFF, 32'h0000_8001, 4'b0000, 32'h0,        1);

        for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            int pat;
            pat      = $urandom_range(0, 3);
            v.rd     = pat[0];
            v.wr     = pat[1];
            v.f3     = 3'($urandom_range(0, 7));
            v.addr   = $urandom;
            v.d2     = $urandom;
            v.fwd    = 2'($urandom_range(0, 3));
            v.wbd    = $urandom;
            v.ack_at = $urandom_range(1, 4);
            v.rdata  = $urandom;
            v = model(v, rd_model, to_model);
            apply(v, $sformatf("rnd%0d", i));
        end

        // Load that never gets an ack: aborted after MAX_WAIT cycles.
        v = mk(1, 0, 3'd2, 32'h0000_0500, 32'h0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 4'b1111, 32'h0, 0);
        v.e_to = 1'b1;
        apply(v, "timeout");
        // timeout_err stays set across a later successful load.
        v = mk(1, 0, 3'd2, 32'h0000_0504, 32'h0, 2'b00, 32'h0, 1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 4'b1111, 32'h0, 0);
        v.e_to = 1'b1;
        apply(v, "sticky");

        // Reset during the second ACCESS cycle of a load.
        ex_mem_memread = 1'b1; ex_mem_memwrite = 1'b0;
        ex_mem_funct3 = 3'd2; ex_mem_result = 32'h0000_0600;
        #1;
        check("rstmid.stall_idle", mem_stall, 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rstmid.req_access2", dmem_req, 1);
        rst = 1'b1;
        ex_mem_memread = 1'b0;
        @(negedge clk);
        #1;
        check("rstmid.dmem_req", dmem_req, 0);
        check("rstmid.read_data", read_data, 0);
        check("rstmid.timeout_err", timeout_err, 0);
        check("rstmid.mem_stall", mem_stall, 0);
        rst = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        check("rstmid.late_ack_read_data", read_data, 0);
        check("rstmid.late_ack_req", dmem_req, 0);
        check("rstmid.late_ack_stall", mem_stall, 0);
        $display("txn rstmid: reset in ACCESS, read_data=%08h dmem_req=%0d", read_data, dmem_req);
        @(negedge clk);
        rd_model = 32'h0;
        to_model = 1'b0;

        v = mk(1, 0, 3'd4, 32'h0000_0007, 32'h0, 2'b00, 32'h0, 1, 32'hAB00_0000, 32'h0000_00AB, 4'b1000, 32'h0, 0);
        apply(v, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
